// File: rtl/wave_pkg.sv
// Shared types for the wave playback voice: volume code and step-period helper.
// Pure declarations; no latency or flow control involved.
package wave_pkg;

    typedef enum logic [1:0] {
        VOL_MUTE    = 2'b00,
        VOL_FULL    = 2'b01,
        VOL_HALF    = 2'b10,
        VOL_QUARTER = 2'b11
    } vol_e;

    // Step period in clk cycles: 2 * (2^freq_w - freq); freq=0 gives the longest period.
    function automatic logic [31:0] step_period(input int unsigned freq_w, input logic [31:0] freq);
        return (32'd1 << (freq_w + 1)) - (freq << 1);
    endfunction

endpackage

// File: rtl/wave_len_counter.sv
// Length counter: loads 2^LEN_W - len_load on load, counts down on enabled len_tick.
// Latency: expire is combinational for the tick edge that takes the count 1->0.
// Backpressure: none; ticks with the counter at 0 are ignored.
module wave_len_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LEN_W-1:0] len_load,
    input  logic             len_tick,
    input  logic             len_en,
    output logic             expire
);

    // One extra bit so len_load=0 holds the full 2^LEN_W count.
    logic [LEN_W:0] len_cnt;

    // A load in the same cycle wins over the tick, so no expiry is reported then.
    assign expire = !load && len_tick && len_en && (len_cnt == (LEN_W+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt <= '0;
        end else if (load) begin
            len_cnt <= {1'b1, {LEN_W{1'b0}}} - {1'b0, len_load};
        end else if (len_tick && len_en && (len_cnt != '0)) begin
            len_cnt <= len_cnt - (LEN_W+1)'(1);
        end
    end

endmodule

// File: rtl/wave_playback_channel.sv
// Wave-table voice: steps pos through a writable sample RAM, scales sample_buf by vol.
// Latency: pos/sample_buf update on the timer-expiry edge; signal is combinational from registers.
// Backpressure: none; writes accepted every cycle. Optional dual bank via WAVE_DUAL_BANK_EN.
module wave_playback_channel
    import wave_pkg::*;
#(
    parameter int SAMPLE_W = 4,
    parameter int DEPTH    = 32,
    parameter int FREQ_W   = 11,
    parameter int LEN_W    = 8,
    localparam int AW      = $clog2(DEPTH),
`ifdef WAVE_DUAL_BANK_EN
    localparam int PW      = AW + 1
`else
    localparam int PW      = AW
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                len_tick,
    input  logic                dac_en,
    input  logic [1:0]          vol,
    input  logic [FREQ_W-1:0]   freq,
    input  logic [LEN_W-1:0]    len_load,
    input  logic                len_en,
    input  logic                trigger,
`ifdef WAVE_DUAL_BANK_EN
    input  logic                bank_sel,
    input  logic                bank_mode,
`endif
    input  logic                wr_en,
    input  logic [PW-1:0]       wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    output logic [SAMPLE_W-1:0] signal,
    output logic                active,
    output logic [PW-1:0]       pos
);

    localparam int RAM_N = 2 ** PW;
    localparam int TW    = FREQ_W + 2;

    logic [SAMPLE_W-1:0] ram [RAM_N];
    logic [SAMPLE_W-1:0] sample_buf;
    logic [TW-1:0]       timer;
    logic [TW-1:0]       period;
    logic                active_q;
    logic [PW-1:0]       pos_q;
    logic [PW-1:0]       next_pos;
    logic [PW-1:0]       start_pos;
    logic                step;
    logic                len_expire;

    assign period = TW'(step_period(FREQ_W, 32'(freq)));
    assign step   = active_q && (timer == TW'(1));

`ifdef WAVE_DUAL_BANK_EN
    logic bank_mode_q;

    assign start_pos = {bank_sel, {AW{1'b0}}};
    // Single-bank mode wraps inside the bank latched at trigger; dual mode runs through both.
    assign next_pos  = bank_mode_q ? (pos_q + PW'(1))
                                   : {pos_q[PW-1], pos_q[AW-1:0] + AW'(1)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_mode_q <= 1'b0;
        end else if (trigger) begin
            bank_mode_q <= bank_mode;
        end
    end
`else
    assign start_pos = '0;
    assign next_pos  = pos_q + PW'(1);
`endif

    wave_len_counter #(
        .LEN_W(LEN_W)
    ) u_len (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (trigger),
        .len_load (len_load),
        .len_tick (len_tick),
        .len_en   (len_en),
        .expire   (len_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_N; i++) begin
                ram[i] <= '0;
            end
        end else if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= '0;
            timer      <= '0;
            active_q   <= 1'b0;
            sample_buf <= '0;
        end else if (trigger) begin
            // Restart holds sample_buf; position 0 is only fetched again on wrap.
            pos_q    <= start_pos;
            timer    <= period;
            active_q <= dac_en;
        end else begin
            if (step) begin
                timer      <= period;
                pos_q      <= next_pos;
                // Write-through so a same-cycle write to the fetched address is not lost.
                sample_buf <= (wr_en && (wr_addr == next_pos)) ? wr_data : ram[next_pos];
            end else if (active_q && (timer != '0)) begin
                timer <= timer - TW'(1);
            end
            if (!dac_en || len_expire) begin
                active_q <= 1'b0;
            end
        end
    end

    always_comb begin
        signal = '0;
        if (active_q) begin
            case (vol_e'(vol))
                VOL_FULL:    signal = sample_buf;
                VOL_HALF:    signal = sample_buf >> 1;
                VOL_QUARTER: signal = sample_buf >> 2;
                default:     signal = '0;
            endcase
        end
    end

    assign active = active_q;
    assign pos    = pos_q;

endmodule

// File: tb/tb_wave_playback_channel.sv
// Bench for wave_playback_channel: vector table, corner sequences, then random traffic vs an event-time model.
module tb_wave_playback_channel;

    localparam int SW = 4;
    localparam int D  = 32;
    localparam int FW = 11;
    localparam int LW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          len_tick = 1'b0;
    logic          dac_en = 1'b0;
    logic [1:0]    vol = 2'd0;
    logic [FW-1:0] freq = '0;
    logic [LW-1:0] len_load = '0;
    logic          len_en = 1'b0;
    logic          trigger = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [SW-1:0] wr_data = '0;
    logic [SW-1:0] signal;
    logic          active;
    logic [AW-1:0] pos;

    always #5 clk = ~clk;

    wave_playback_channel dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .len_tick (len_tick),
        .dac_en   (dac_en),
        .vol      (vol),
        .freq     (freq),
        .len_load (len_load),
        .len_en   (len_en),
        .trigger  (trigger),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .signal   (signal),
        .active   (active),
        .pos      (pos)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: absolute edge number of the next step instead of a down-counter.
    int m_mem [D];
    int m_pos, m_buf, m_len, edge_no, m_next;
    bit m_act;

    function automatic void model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = 0;
        m_pos = 0; m_buf = 0; m_len = 0; m_act = 0; m_next = -1;
    endfunction

    function automatic int m_signal();
        if (!m_act || vol == 2'd0) return 0;
        return m_buf >> (int'(vol) - 1);
    endfunction

    function automatic void model_edge();
        int p;
        bit expire;
        p = 2 * ((1 << FW) - int'(freq));
        expire = 0;
        edge_no++;
        if (trigger) begin
            m_pos  = 0;
            m_next = edge_no + p;
            m_len  = (1 << LW) - int'(len_load);
            m_act  = dac_en;
        end else begin
            if (m_act && edge_no == m_next) begin
                m_pos  = (m_pos + 1) % D;
                m_buf  = (wr_en && int'(wr_addr) == m_pos) ? int'(wr_data) : m_mem[m_pos];
                m_next = edge_no + p;
            end
            if (len_tick && len_en && m_len > 0) begin
                m_len--;
                if (m_len == 0) expire = 1;
            end
            if (!dac_en || expire) m_act = 0;
        end
        if (wr_en) m_mem[wr_addr] = int'(wr_data);
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_model(input string name);
        check({name, " signal"}, int'(signal), m_signal());
        check({name, " active"}, int'(active), int'(m_act));
        check({name, " pos"},    int'(pos),    m_pos);
    endtask

    task automatic idle_inputs();
        trigger = 0; len_tick = 0; wr_en = 0;
    endtask

    typedef struct {
        int trig; int fr; int vl; int dac; int tk; int len_e; int ll;
        int we; int wa; int wd;
        int e_sig; int e_act; int e_pos;
    } vec_t;

    vec_t vq[$];

    initial begin
        edge_no = 0;
        model_reset();

        // trig freq vol dac tick len_en len_load | wr_en addr data | signal active pos
        vq.push_back('{0,    0,0,0,0,0,  0, 1,1,15,  0,0,0});
        vq.push_back('{0,    0,0,0,0,0,  0, 1,2, 6,  0,0,0});
        vq.push_back('{1, 2047,2,1,0,0,  0, 0,0, 0,  0,1,0});
        vq.push_back('{0, 2047,2,1,0,0,  0, 0,0, 0,  0,1,0});
        vq.push_back('{0, 2047,2,1,0,0,  0, 0,0, 0,  7,1,1});
        vq.push_back('{0, 2047,3,1,0,0,  0, 0,0, 0,  3,1,1});
        vq.push_back('{0, 2047,3,1,0,0,  0, 0,0, 0,  1,1,2});
        vq.push_back('{0, 2047,0,1,0,0,  0, 0,0, 0,  0,1,2});
        vq.push_back('{0, 2046,1,1,0,0,  0, 1,3,10, 10,1,3});
        vq.push_back('{0, 2046,1,1,0,0,  0, 0,0, 0, 10,1,3});
        vq.push_back('{0, 2046,1,1,0,0,  0, 0,0, 0, 10,1,3});
        vq.push_back('{0, 2046,1,1,0,0,  0, 0,0, 0, 10,1,3});
        vq.push_back('{0, 2046,1,1,0,0,  0, 1,4, 5,  5,1,4});
        vq.push_back('{1, 2047,1,1,0,1,254, 0,0, 0,  5,1,0});
        vq.push_back('{0, 2047,1,1,1,1,  0, 0,0, 0,  5,1,0});
        vq.push_back('{0, 2047,1,1,1,1,  0, 0,0, 0,  0,0,1});
        vq.push_back('{0, 2047,1,1,1,1,  0, 0,0, 0,  0,0,1});
        vq.push_back('{1, 2047,1,0,0,0,  0, 0,0, 0,  0,0,0});
        vq.push_back('{1, 2047,1,1,0,0,  0, 0,0, 0, 15,1,0});
        vq.push_back('{0, 2047,1,0,0,0,  0, 0,0, 0,  0,0,0});
        vq.push_back('{0, 2047,1,1,0,0,  0, 0,0, 0,  0,0,0});

        // Reset held, then released with no trigger.
        repeat (3) @(posedge clk);
        #1;
        check("reset signal", int'(signal), 0);
        check("reset active", int'(active), 0);
        check("reset pos",    int'(pos),    0);
        rst_n = 1;
        repeat (2) begin
            tick();
            check_model("idle");
            check("idle active", int'(active), 0);
        end

        foreach (vq[i]) begin
            trigger  = vq[i].trig[0];
            freq     = FW'(vq[i].fr);
            vol      = 2'(vq[i].vl);
            dac_en   = vq[i].dac[0];
            len_tick = vq[i].tk[0];
            len_en   = vq[i].len_e[0];
            len_load = LW'(vq[i].ll);
            wr_en    = vq[i].we[0];
            wr_addr  = AW'(vq[i].wa);
            wr_data  = SW'(vq[i].wd);
            tick();
            check($sformatf("vec%0d signal", i), int'(signal), vq[i].e_sig);
            check($sformatf("vec%0d active", i), int'(active), vq[i].e_act);
            check($sformatf("vec%0d pos", i),    int'(pos),    vq[i].e_pos);
            check_model($sformatf("vec%0d model", i));
        end

        // Wrap: minimum period, 64 edges take pos 0..31 and back to 0.
        idle_inputs();
        trigger = 1; freq = 11'd2047; dac_en = 1; vol = 2'd1; len_en = 0;
        tick();
        idle_inputs();
        for (int k = 1; k <= 64; k++) begin
            tick();
            check_model("wrap run");
            if (k == 62) check("wrap pos31", int'(pos), 31);
            if (k == 64) check("wrap pos0", int'(pos), 0);
        end

        // Retrigger at pos=17 coinciding with a len_tick: reload wins, no decrement.
        trigger = 1; len_load = 8'd253; len_en = 1;
        tick();
        idle_inputs();
        repeat (34) tick();
        check("mid pos17", int'(pos), 17);
        trigger = 1; len_tick = 1;
        tick();
        idle_inputs();
        check("mid retrig pos", int'(pos), 0);
        check("mid retrig active", int'(active), 1);
        for (int t = 1; t <= 3; t++) begin
            len_tick = 1;
            tick();
            len_tick = 0;
            tick();
            check($sformatf("mid tick%0d active", t), int'(active), (t < 3) ? 1 : 0);
            check_model("mid tick");
        end

        // Reset mid-play is immediate; first edge after release is idle.
        trigger = 1; len_en = 0;
        tick();
        idle_inputs();
        repeat (5) tick();
        rst_n = 0;
        #1;
        check("async rst active", int'(active), 0);
        check("async rst pos",    int'(pos),    0);
        check("async rst signal", int'(signal), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        tick();
        check_model("post reset");
        check("post reset active", int'(active), 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            trigger  = ($urandom_range(0, 29) == 0);
            freq     = FW'(2047 - $urandom_range(0, 3));
            vol      = 2'($urandom_range(0, 3));
            dac_en   = ($urandom_range(0, 63) != 0);
            len_tick = ($urandom_range(0, 7) == 0);
            len_en   = ($urandom_range(0, 3) != 0);
            len_load = LW'($urandom_range(240, 255));
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = ($urandom_range(0, 1) == 0) ? AW'((m_pos + 1) % D) : AW'($urandom_range(0, D - 1));
            wr_data  = SW'($urandom_range(0, 15));
            tick();
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
